branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_compare.sv | 38 +++
 rtl/branch_unit.sv | 179 +++++++++++++++++
 tb/tb_branch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution unit.
//   funct3_e    : conditional-branch operation codes (instruction bits 14:12)
//   INSTR_BYTES : size of one instruction, used for the fall-through pc
// -----------------------------------------------------------------------------
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'd0,
        BNE  = 3'd1,
        BLT  = 3'd4,
        BGE  = 3'd5,
        BLTU = 3'd6,
        BGEU = 3'd7
    } funct3_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_compare.sv
// -----------------------------------------------------------------------------
// branch_compare
// Combinational branch condition evaluator.
// Ports:
//   lhs, rhs  in  DATA_WIDTH  rs1 / rs2 operand values
//   funct3    in  3           branch operation code
//   cond      out 1           branch condition holds (0 when illegal)
//   legal     out 1           funct3 names a defined branch operation
// -----------------------------------------------------------------------------
module branch_compare
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic [2:0]            funct3,
    output logic                  cond,
    output logic                  legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3_e'(funct3))
            BEQ:     cond = (lhs == rhs);
            BNE:     cond = (lhs != rhs);
            BLT:     cond = ($signed(lhs) <  $signed(rhs));
            BGE:     cond = ($signed(lhs) >= $signed(rhs));
            BLTU:    cond = (lhs <  rhs);
            BGEU:    cond = (lhs >= rhs);
            default: legal = 1'b0;   // funct3 2 and 3 are undefined
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Elastic 1- or 2-stage branch resolution pipeline with valid/ready handshakes.
// Optional feature macro: BRANCH_PREDICT_EN
//   defined : mispredict = legal && (taken != predicted_taken)
//   absent  : predicted_taken ignored, mispredict = legal && taken
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake
//   lhs, rhs, funct3         operands and branch operation
//   pc, imm                  branch address and sign-extended offset
//   predicted_taken          front-end prediction
//   flush                    kill every in-flight request
//   out_valid / out_ready    result handshake
//   taken, illegal, misaligned, mispredict   resolved flags
//   target, next_pc          branch target and resolved successor pc
// -----------------------------------------------------------------------------
module branch_unit
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] imm,
    input  logic                  predicted_taken,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  taken,
    output logic                  illegal,
    output logic                  misaligned,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] next_pc
);

    generate
        if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
            $error("branch_unit: STAGES must be 1 or 2");
        end
    endgenerate

    // Comparison result plus target sum: what stage 0 holds when STAGES=2.
    typedef struct packed {
        logic                  cond;
        logic                  legal;
        logic                  pred;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
    } pay_t;

    // Fully resolved result presented on the output ports.
    typedef struct packed {
        logic                  taken;
        logic                  illegal;
        logic                  misaligned;
        logic                  mispredict;
        logic [ADDR_WIDTH-1:0] target;
        logic [ADDR_WIDTH-1:0] next_pc;
    } res_t;

    logic cmp_cond;
    logic cmp_legal;
    pay_t in_pay;
    pay_t rpay;        // payload feeding the resolve logic
    res_t rres;
    res_t out_q;
    logic out_valid_q;
    logic out_valid_d;

    branch_compare #(.DATA_WIDTH(DATA_WIDTH)) u_compare (
        .lhs    (lhs),
        .rhs    (rhs),
        .funct3 (funct3),
        .cond   (cmp_cond),
        .legal  (cmp_legal)
    );

    assign in_pay = '{cond:   cmp_cond,
                      legal:  cmp_legal,
                      pred:   predicted_taken,
                      pc:     pc,
                      target: pc + imm};   // wraps modulo 2^ADDR_WIDTH

    always_comb begin
        rres            = '0;
        rres.taken      = rpay.legal && rpay.cond;
        rres.illegal    = !rpay.legal;
        rres.target     = rpay.target;
        rres.misaligned = rres.taken && (rpay.target[1:0] != 2'b00);
        rres.next_pc    = rres.taken ? rpay.target
                                     : rpay.pc + ADDR_WIDTH'(INSTR_BYTES);
`ifdef BRANCH_PREDICT_EN
        rres.mispredict = rpay.legal && (rres.taken != rpay.pred);
`else
        rres.mispredict = rpay.legal && rres.taken;   // static not-taken
`endif
    end

`ifndef BRANCH_PREDICT_EN
    logic unused_pred;
    assign unused_pred = rpay.pred;
`endif

    generate
        if (STAGES == 2) begin : g_two
            logic s0_valid_q;
            logic s0_valid_d;
            pay_t s0_q;
            logic s1_free;
            logic s0_adv;

            assign s1_free  = !out_valid_q || out_ready;
            assign s0_adv   = s0_valid_q && s1_free;
            assign in_ready = !rst && (!s0_valid_q || s1_free);
            assign rpay     = s0_q;

            always_comb begin
                s0_valid_d  = s0_valid_q;
                out_valid_d = out_valid_q;
                if (in_ready) s0_valid_d  = in_valid;
                if (s1_free)  out_valid_d = s0_valid_q;
                if (flush) begin
                    s0_valid_d  = 1'b0;
                    out_valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // register samples pre-edge values regardless of block order.
                if (rst) begin
                    s0_valid_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end else begin
                    s0_valid_q  <= s0_valid_d;
                    out_valid_q <= out_valid_d;
                end
                // NOTE: data registers are deliberately left out of reset; the
                // valid bits alone decide whether their contents mean anything.
                if (in_valid && in_ready) s0_q  <= in_pay;
                if (s0_adv)               out_q <= rres;
            end
        end else begin : g_one
            assign in_ready = !rst && (!out_valid_q || out_ready);
            assign rpay     = in_pay;

            always_comb begin
                out_valid_d = out_valid_q;
                if (in_ready) out_valid_d = in_valid;
                if (flush)    out_valid_d = 1'b0;
            end

            always_ff @(posedge clk) begin
                if (rst) out_valid_q <= 1'b0;
                else     out_valid_q <= out_valid_d;
                if (in_valid && in_ready) out_q <= rres;
            end
        end
    endgenerate

    assign out_valid  = out_valid_q;
    assign taken      = out_q.taken;
    assign illegal    = out_q.illegal;
    assign misaligned = out_q.misaligned;
    assign mispredict = out_q.mispredict;
    assign target     = out_q.target;
    assign next_pc    = out_q.next_pc;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
// Scoreboard bench for branch_unit (STAGES=2): accepted requests push a
// reference result, a monitor pops and compares each delivered result.
// -----------------------------------------------------------------------------
module tb_branch_unit;

    localparam int STAGES = 2;
`ifdef BRANCH_PREDICT_EN
    localparam logic PRED_EN = 1'b1;
`else
    localparam logic PRED_EN = 1'b0;
`endif

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic        misaligned;
        logic        mispredict;
        logic [31:0] target;
        logic [31:0] next_pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] lhs = '0, rhs = '0, pc = '0, imm = '0;
    logic [2:0]  funct3 = '0;
    logic        predicted_taken = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        taken, illegal, misaligned, mispredict;
    logic [31:0] target, next_pc;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   delivered = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: toggle, 2: random, 3: hold
    exp_t sb[$];
    exp_t got, held, e;
    logic stalled = 1'b0;

    branch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STAGES(STAGES)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .lhs             (lhs),
        .rhs             (rhs),
        .funct3          (funct3),
        .pc              (pc),
        .imm             (imm),
        .predicted_taken (predicted_taken),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .taken           (taken),
        .illegal         (illegal),
        .misaligned      (misaligned),
        .mispredict      (mispredict),
        .target          (target),
        .next_pc         (next_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: branch semantics from the architectural rules.
    function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] p, input logic [31:0] off, input logic pred);
        exp_t r;
        logic ok, c;
        ok = 1'b1;
        c  = 1'b0;
        case (f3)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = ($signed(a) < $signed(b));
            3'd5: c = !($signed(a) < $signed(b));
            3'd6: c = (a < b);
            3'd7: c = !(a < b);
            default: ok = 1'b0;
        endcase
        r.target     = p + off;
        r.taken      = ok && c;
        r.illegal    = !ok;
        r.misaligned = r.taken && ((r.target % 4) != 0);
        r.next_pc    = r.taken ? r.target : p + 32'd4;
        r.mispredict = PRED_EN ? (ok && (r.taken != pred)) : (ok && r.taken);
        return r;
    endfunction

    // Input monitor: record what the DUT accepts.
    always @(negedge clk) begin
        if (rst || flush) sb.delete();
        else if (in_valid && in_ready)
            sb.push_back(model(funct3, lhs, rhs, pc, imm, predicted_taken));
    end

    // Output monitor: compare delivered results and stall stability.
    always @(negedge clk) begin
        got = '{taken, illegal, misaligned, mispredict, target, next_pc};
        if (rst || flush) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid_held", out_valid, 1'b1);
                if (out_valid) check("stall_data_stable", got, held);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", out_valid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        delivered++;
                        check("taken",      taken,      e.taken);
                        check("illegal",    illegal,    e.illegal);
                        check("misaligned", misaligned, e.misaligned);
                        check("mispredict", mispredict, e.mispredict);
                        check("target",     target,     e.target);
                        check("next_pc",    next_pc,    e.next_pc);
                    end
                end else begin
                    stalled = 1'b1;
                    held    = got;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    // Present a request and hold it until accepted; in_valid is left high.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] off, input logic pred);
        logic acc;
        acc = 1'b0;
        funct3 = f3; lhs = a; rhs = b; pc = p; imm = off; predicted_taken = pred;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready && !flush && !rst;
            tick();
        end
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic send_rand();
        logic [31:0] a, b, p, off;
        a   = $urandom();
        b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 8)));
        p   = {$urandom(), 2'b00} >> 0;
        off = 32'($urandom_range(0, 255)) * 32'd2 - 32'd256;
        send(3'($urandom_range(0, 7)), a, b, p, off, 1'($urandom_range(0, 1)));
    endtask

    // Wait for out_valid after a send; returns elapsed cycles since acceptance.
    task automatic wait_out(output int cyc);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check("out_valid_seen", out_valid, 1'b1);
    endtask

    task automatic drain();
        rdy_mode = 0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 500 && (sb.size() != 0 || out_valid); i++) tick();
    endtask

    initial begin
        int cyc;
        int base;

        // Reset behaviour
        repeat (3) tick();
        check("rst_in_ready_low", in_ready, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_in_ready", in_ready, 1'b1);

        // BEQ taken, latency equals STAGES
        send(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        wait_out(cyc);
        check("latency", cyc, STAGES);
        check("beq_taken", taken, 1'b1);
        check("beq_target", target, 32'h120);
        check("beq_next_pc", next_pc, 32'h120);

        // Signed vs unsigned less-than
        send(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
        wait_out(cyc);
        check("blt_taken", taken, 1'b1);
        send(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
        wait_out(cyc);
        check("bltu_taken", taken, 1'b0);
        check("bltu_next_pc", next_pc, 32'h204);

        // Illegal funct3 and target wrap
        send(3'd3, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8, 1'b1);
        wait_out(cyc);
        check("f3_3_illegal", illegal, 1'b1);
        check("f3_3_taken", taken, 1'b0);
        check("f3_3_mispredict", mispredict, 1'b0);
        check("f3_3_misaligned", misaligned, 1'b0);
        check("wrap_target", target, 32'h4);
        check("wrap_next_pc", next_pc, 32'h0);
        send(3'd2, 32'd0, 32'd0, 32'h40, 32'h8, 1'b0);
        wait_out(cyc);
        check("f3_2_illegal", illegal, 1'b1);
        check("f3_2_next_pc", next_pc, 32'h44);

        // Misaligned taken target
        send(3'd0, 32'd1, 32'd1, 32'h100, 32'h6, 1'b0);
        wait_out(cyc);
        check("misaligned_flag", misaligned, 1'b1);

        // Prediction: BNE not taken with predicted_taken=1
        send(3'd1, 32'd7, 32'd7, 32'h300, 32'h40, 1'b1);
        wait_out(cyc);
        check("bne_mispredict", mispredict, PRED_EN);
        drain();

        // Back-to-back 8 with out_ready toggling
        base = delivered;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        check("b2b_delivered", delivered - base, 8);

        // Flush with two in flight plus a request offered in the flush cycle
        rdy_mode = 3;
        out_ready = 1'b0;
        send(3'd0, 32'd1, 32'd1, 32'h500, 32'h10, 1'b0);
        send(3'd1, 32'd1, 32'd2, 32'h600, 32'h10, 1'b0);
        funct3 = 3'd0; lhs = 32'd3; rhs = 32'd3; pc = 32'h700; imm = 32'h10;
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("flush_no_out_valid", out_valid, 1'b0);
            tick();
        end
        rdy_mode = 0;
        send(3'd5, 32'd9, 32'd2, 32'h800, 32'h20, 1'b0);
        wait_out(cyc);
        check("post_flush_taken", taken, 1'b1);
        check("post_flush_target", target, 32'h820);
        drain();

        // Reset mid-operation
        rdy_mode = 3;
        out_ready = 1'b0;
        send_rand();
        send_rand();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("after_rst_out_valid", out_valid, 1'b0);

        // Random traffic with random backpressure and occasional flush
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                in_valid = 1'b0;
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        drain();
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
